// File: rtl/mul_iter_pkg.sv
// Shared types for the iterative signed multiplier.
package mul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FIX    = 2'd2,
    RESULT = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_iter_twos_abs.sv
// Two's-complement sign/magnitude split; the most negative value maps to
// 2^(W-1), which still fits the W-bit unsigned magnitude.
module twos_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] mag,
  output logic         neg
);

  assign neg = value[W-1];
  assign mag = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_iter.sv
// Iterative signed shift-add multiplier, one partial product per clock.
// Optional MUL_ITER_ZERO_BYPASS_EN: a zero operand skips straight to RESULT.
//
// Streams: a beat moves on a rising edge where tvalid and tready are both 1.
// Both operand streams transfer together on one edge; each ready reflects the
// other stream's valid, so a lone operand stays pending. The producer holds
// tvalid/tdata until it transfers; data_tdata_o is stable while it waits.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic [XLEN-1:0] data1_tdata_i,
  input  logic            data1_tvalid_i,
  output logic            data1_tready_o,
  input  logic [XLEN-1:0] data2_tdata_i,
  input  logic            data2_tvalid_i,
  output logic            data2_tready_o,
  output logic [2*XLEN-1:0] data_tdata_o,
  output logic            data_tvalid_o,
  input  logic            data_tready_i,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_CALC   = CALC;
  localparam logic [1:0] S_FIX    = FIX;
  localparam logic [1:0] S_RESULT = RESULT;

  logic [1:0]        state_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN:0]     acc_q;
  logic              sign_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] prod_q;

  logic [XLEN-1:0]   a_mag, b_mag;
  logic              a_neg, b_neg;
  logic              accept;
  logic              bypass;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mag;

  twos_abs #(.W(XLEN)) u_abs_a (.value(data1_tdata_i), .mag(a_mag), .neg(a_neg));
  twos_abs #(.W(XLEN)) u_abs_b (.value(data2_tdata_i), .mag(b_mag), .neg(b_neg));

  assign data1_tready_o = arstn_i & (state_q == S_IDLE) & data2_tvalid_i;
  assign data2_tready_o = arstn_i & (state_q == S_IDLE) & data1_tvalid_i;
  assign accept         = (state_q == S_IDLE) & data1_tvalid_i & data2_tvalid_i;

`ifdef MUL_ITER_ZERO_BYPASS_EN
  assign bypass = (data1_tdata_i == '0) | (data2_tdata_i == '0);
`else
  assign bypass = 1'b0;
`endif

  // acc and multiplier shift as one 2*XLEN+1-bit register
  assign sum = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign mag = {acc_q[XLEN-1:0], mplier_q};

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            sign_q   <= a_neg ^ b_neg;
            acc_q    <= '0;
            cnt_q    <= CW'(XLEN);
            if (bypass) begin
              prod_q  <= '0;
              state_q <= S_RESULT;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q    <= {1'b0, sum[XLEN:1]};
          mplier_q <= {sum[0], mplier_q[XLEN-1:1]};
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          prod_q  <= sign_q ? -mag : mag;
          state_q <= S_RESULT;
        end
        S_RESULT: begin
          if (data_tready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_tdata_o  = prod_q;
  assign data_tvalid_o = (state_q == S_RESULT);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter (XLEN=16); honours MUL_ITER_ZERO_BYPASS_EN.
module tb_mul_iter;

  logic        clk;
  logic        arstn;
  logic [15:0] d1, d2;
  logic        v1, v2, r1, r2;
  logic [31:0] dout;
  logic        vout, rdy;
  logic [1:0]  dbg;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int zero_lat;

  mul_iter #(.XLEN(16)) dut (
    .clk_i          (clk),
    .arstn_i        (arstn),
    .data1_tdata_i  (d1),
    .data1_tvalid_i (v1),
    .data1_tready_o (r1),
    .data2_tdata_i  (d2),
    .data2_tvalid_i (v2),
    .data2_tready_o (r2),
    .data_tdata_o   (dout),
    .data_tvalid_o  (vout),
    .data_tready_i  (rdy),
    .dbg_state      (dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents both operands, accepts them, then waits (bounded) for tvalid.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int n;
    d1 = a; d2 = b; v1 = 1'b1; v2 = 1'b1;
    #1;
    check({tag, " accept readies"}, {62'd0, r1, r2}, 64'd3);
    tick();
    v1 = 1'b0; v2 = 1'b0;
    d1 = 16'($urandom_range(0, 65535));
    d2 = 16'($urandom_range(0, 65535));
    n = 1;
    while (!vout && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " tvalid"}, {63'd0, vout}, 64'd1);
    check({tag, " product"}, {32'd0, dout}, {32'd0, exp});
  endtask

  task automatic transfer(input string tag);
    rdy = 1'b1;
    tick();
    check({tag, " tvalid after xfer"}, {63'd0, vout}, 64'd0);
    check({tag, " idle after xfer"}, {62'd0, dbg}, 64'd0);
  endtask

  initial begin
`ifdef MUL_ITER_ZERO_BYPASS_EN
    zero_lat = 1;
`else
    zero_lat = 18;
`endif
    arstn = 1'b0; rdy = 1'b1;
    d1 = 16'h1111; d2 = 16'h2222; v1 = 1'b1; v2 = 1'b1;
    #12;
    check("reset tdata", {32'd0, dout}, 64'd0);
    check("reset tvalid", {63'd0, vout}, 64'd0);
    check("reset readies", {62'd0, r1, r2}, 64'd0);
    check("reset state", {62'd0, dbg}, 64'd0);
    v1 = 1'b0; v2 = 1'b0;
    arstn = 1'b1;
    tick();

    run_op("7x-3", 16'd7, 16'hFFFD, 32'hFFFF_FFEB, 18);
    transfer("7x-3");
    run_op("min*min", 16'h8000, 16'h8000, 32'h4000_0000, 18);
    transfer("min*min");
    run_op("min*1", 16'h8000, 16'h0001, 32'hFFFF_8000, 18);
    transfer("min*1");
    run_op("max*max", 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 18);
    transfer("max*max");

    // Lone multiplicand must stay pending.
    d1 = 16'd9; d2 = 16'd11; v1 = 1'b1; v2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("lone data1_tready", {63'd0, r1}, 64'd0);
      check("lone state idle", {62'd0, dbg}, 64'd0);
      tick();
    end
    run_op("lone", 16'd9, 16'd11, 32'h0000_0063, 18);
    transfer("lone");
    for (int i = 0; i < 3; i++) begin
      check("lone single product", {62'd0, dbg, vout}, 64'd0);
      tick();
    end

    // Back-pressure in RESULT with both operand valids asserted.
    rdy = 1'b0;
    run_op("hold", 16'd100, 16'd200, 32'h0000_4E20, 18);
    d1 = 16'd5; d2 = 16'd5; v1 = 1'b1; v2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("hold tvalid", {63'd0, vout}, 64'd1);
      check("hold tdata", {32'd0, dout}, 64'h4E20);
      check("hold readies", {62'd0, r1, r2}, 64'd0);
      tick();
    end
    v1 = 1'b0; v2 = 1'b0;
    transfer("hold");

    // Abort in the middle of CALC.
    d1 = 16'd5; d2 = 16'd6; v1 = 1'b1; v2 = 1'b1;
    tick();
    v1 = 1'b0; v2 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort in calc", {62'd0, dbg}, 64'd1);
    #2 arstn = 1'b0;
    #1;
    check("abort tdata", {32'd0, dout}, 64'd0);
    check("abort tvalid", {63'd0, vout}, 64'd0);
    check("abort state", {62'd0, dbg}, 64'd0);
    v1 = 1'b1; v2 = 1'b1;
    #1;
    check("abort readies", {62'd0, r1, r2}, 64'd0);
    v1 = 1'b0; v2 = 1'b0;
    #3 arstn = 1'b1;
    tick();
    run_op("3x4", 16'd3, 16'd4, 32'h0000_000C, 18);
    transfer("3x4");

    // Zero operand after a nonzero product so a stale value would show.
    run_op("zero", 16'd0, 16'h1234, 32'h0000_0000, zero_lat);
    transfer("zero");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
